i2c_init_sequencer: RTL and testbench
=====================================

I2C_INIT_SEQUENCER -- requirements
Module: i2c_init_sequencer

Interface
REQ-001 Parameter ADDR, default 7'h1A: 7-bit I2C slave address driven on gen_addr.
REQ-002 Parameter NUM_REGS, default 4: register-write table depth, range 1..256.
REQ-003 Parameter DATA_W, default 16: table word width; format is {reg_addr, reg_value}.
REQ-004 Parameter GAP_CYCLES, default 0: idle clk cycles inserted between consecutive writes.
REQ-005 Parameter MAX_RETRY, default 2: retries per entry after NACK (see REQ-024).
REQ-006 Let AW = max(1, $clog2(NUM_REGS)).
REQ-007 clk  input  1  clock; all logic on rising edge.
REQ-008 reset  input  1  reset, synchronous, active-high.
REQ-009 init  input  1  start pulse; begins the table sequence.
REQ-010 tbl_we  input  1  table write strobe.
REQ-011 tbl_addr  input  AW  table write index.
REQ-012 tbl_wdata  input  DATA_W  table write data.
REQ-013 gen_load  output  1  one-cycle request to the I2C transaction generator.
REQ-014 gen_addr  output  7  constant ADDR.
REQ-015 gen_data  output  DATA_W  word for the current transaction; valid while gen_load=1.
REQ-016 gen_ready  input  1  one-cycle pulse from the generator when the transaction completes.
REQ-017 gen_nack  input  1  slave NACK status; sampled only when gen_ready=1.
REQ-018 busy  output  1  sequence in progress.
REQ-019 done  output  1  one-cycle pulse when every entry has been ACKed.
REQ-020 error  output  1  sticky flag; the sequence aborted on NACK.
REQ-021 err_index  output  AW  table index of the failing entry; valid while error=1.

Function
REQ-022 States and transitions:
- IDLE: on init, clear error, set idx=0 and retry=0, go to ISSUE.
- ISSUE: assert gen_load for one cycle with gen_data=table[idx], then go to WAIT.
- WAIT: hold until gen_ready=1.
- GAP: count GAP_CYCLES cycles, then go to ISSUE. When GAP_CYCLES=0, GAP is skipped and the next state is ISSUE directly.
REQ-023 WAIT on gen_ready with gen_nack=0:
- if idx==NUM_REGS-1, pulse done and go to IDLE;
- otherwise idx++, retry=0, go to GAP.
REQ-024 WAIT on gen_ready with gen_nack=1:
- retry enabled (REQ-033) and retry<MAX_RETRY: retry++, go to GAP, then reissue the same idx;
- otherwise: error=1, err_index=idx, go to IDLE with no done pulse.
REQ-025 busy=1 in every state except IDLE; init is ignored while busy=1.
REQ-026 Table writes:
- accepted only when busy=0 and tbl_addr<NUM_REGS;
- otherwise dropped silently.
REQ-027 init and tbl_we in the same IDLE cycle: the write completes first; the sequence uses the new value.
REQ-028 gen_ready pulses outside WAIT are ignored.
REQ-029 Latency: init to first gen_load is exactly 1 cycle. gen_ready to next gen_load is GAP_CYCLES+1 cycles.

Reset
REQ-030 Reset state: state=IDLE, idx=0, retry=0, gap counter=0.
REQ-031 Reset output values: gen_load=0, gen_data=0, busy=0, done=0, error=0, err_index=0.
REQ-032 Reset clears every table entry to 0 and aborts any sequence in progress immediately; no further gen_load is issued.

Configuration
REQ-033 Macro I2C_INIT_RETRY_EN:
- defined: NACK retry per REQ-024 is enabled;
- undefined: retry logic and the retry counter are omitted, MAX_RETRY is ignored, and the first NACK aborts.

Verification
REQ-034 The bench SHALL cover the following scenarios (NUM_REGS=4, GAP_CYCLES=3 unless stated):
- Table {05AA,0112,0255,00DE}, init, all ACK -> four gen_load pulses in that order, 4 cycles apart after each gen_ready, done pulse, busy low.
- NACK on idx 2 twice, then ACK, retry enabled -> 0255 issued 3 times, sequence completes, error=0.
- NACK on idx 1 three times, retry enabled -> 0112 issued 3 times, error=1, err_index=1, no done.
- Macro undefined, NACK on idx 0 -> single 05AA issue, error=1, err_index=0.
- tbl_we to idx 1 (data 0177) while busy -> dropped; tbl_addr=5 in IDLE -> dropped; second init while busy -> ignored.
- reset asserted in WAIT on idx 2 -> next cycle busy=0, gen_load=0, table reads 0; new init issues 0000.

Source files
------------

// File: rtl/i2c_init_sequencer.sv
// rtl/i2c_init_sequencer.sv - I2C register-write init sequencer driving a transaction generator
// Optional NACK retry is compiled in with I2C_INIT_RETRY_EN.
module i2c_init_sequencer #(
  parameter logic [6:0] ADDR       = 7'h1A,
  parameter int         NUM_REGS   = 4,
  parameter int         DATA_W     = 16,
  parameter int         GAP_CYCLES = 0,
  parameter int         MAX_RETRY  = 2,
  localparam int        AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              tbl_we,
  input  logic [AW-1:0]     tbl_addr,
  input  logic [DATA_W-1:0] tbl_wdata,
  output logic              gen_load,
  output logic [6:0]        gen_addr,
  output logic [DATA_W-1:0] gen_data,
  input  logic              gen_ready,
  input  logic              gen_nack,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [AW-1:0]     err_index
);

  localparam int            GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

  state_t            state;
  logic [AW-1:0]     idx;
  logic [AW-1:0]     nxt_idx;
  logic [GW-1:0]     gap_cnt;
  logic [DATA_W-1:0] table_mem [NUM_REGS];
  logic              tbl_ok;
  logic              retry_ok;

`ifdef I2C_INIT_RETRY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] retry;
  assign retry_ok = (int'(retry) < MAX_RETRY);
`else
  assign retry_ok = 1'b0;
`endif

  assign gen_addr = ADDR;
  assign tbl_ok   = tbl_we && (state == S_IDLE) && (int'(tbl_addr) < NUM_REGS);
  // A NACK that is retried reissues the same entry; an ACK advances.
  assign nxt_idx  = gen_nack ? idx : idx + AW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      gap_cnt   <= '0;
      gen_load  <= 1'b0;
      gen_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_index <= '0;
`ifdef I2C_INIT_RETRY_EN
      retry     <= '0;
`endif
      for (int i = 0; i < NUM_REGS; i++) table_mem[i] <= '0;
    end else begin
      gen_load <= 1'b0;
      done     <= 1'b0;
      if (tbl_ok) table_mem[tbl_addr] <= tbl_wdata;

      case (state)
        S_IDLE: begin
          if (init) begin
            state    <= S_ISSUE;
            busy     <= 1'b1;
            error    <= 1'b0;
            idx      <= '0;
`ifdef I2C_INIT_RETRY_EN
            retry    <= '0;
`endif
            gen_load <= 1'b1;
            // Forward a same-cycle write to entry 0 so the first issue sees the new word.
            gen_data <= (tbl_ok && tbl_addr == '0) ? tbl_wdata : table_mem[0];
          end
        end

        S_ISSUE: state <= S_WAIT;

        S_WAIT: begin
          if (gen_ready) begin
            if (!gen_nack && idx == LAST_IDX) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else if (!gen_nack || retry_ok) begin
              idx <= nxt_idx;
`ifdef I2C_INIT_RETRY_EN
              retry <= gen_nack ? retry + RW'(1) : '0;
`endif
              if (GAP_CYCLES == 0) begin
                state    <= S_ISSUE;
                gen_load <= 1'b1;
                gen_data <= table_mem[nxt_idx];
              end else begin
                state   <= S_GAP;
                gap_cnt <= '0;
              end
            end else begin
              error     <= 1'b1;
              err_index <= idx;
              busy      <= 1'b0;
              state     <= S_IDLE;
            end
          end
        end

        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state    <= S_ISSUE;
            gen_load <= 1'b1;
            gen_data <= table_mem[idx];
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// tb/tb_i2c_init_sequencer.sv - scoreboard bench for i2c_init_sequencer
// Main instance: NUM_REGS=4, GAP_CYCLES=3; second instance: NUM_REGS=5, GAP_CYCLES=0.
module tb_i2c_init_sequencer;
  localparam int GAP = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        init = 1'b0;
  logic        tbl_we = 1'b0;
  logic [1:0]  tbl_addr = '0;
  logic [15:0] tbl_wdata = '0;
  logic        gen_ready = 1'b0;
  logic        gen_nack = 1'b0;
  logic        gen_load, busy, done, error;
  logic [6:0]  gen_addr;
  logic [15:0] gen_data;
  logic [1:0]  err_index;

  logic        init5 = 1'b0;
  logic        tbl_we5 = 1'b0;
  logic [2:0]  tbl_addr5 = '0;
  logic [15:0] tbl_wdata5 = '0;
  logic        gen_ready5 = 1'b0;
  logic        gen_nack5 = 1'b0;
  logic        gen_load5, busy5, done5, error5;
  logic [6:0]  gen_addr5;
  logic [15:0] gen_data5;
  logic [2:0]  err_index5;

  i2c_init_sequencer #(.ADDR(7'h1A), .NUM_REGS(4), .DATA_W(16), .GAP_CYCLES(GAP), .MAX_RETRY(2)) dut (
    .clk(clk), .reset(reset), .init(init), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_wdata(tbl_wdata), .gen_load(gen_load), .gen_addr(gen_addr), .gen_data(gen_data),
    .gen_ready(gen_ready), .gen_nack(gen_nack), .busy(busy), .done(done), .error(error),
    .err_index(err_index));

  i2c_init_sequencer #(.ADDR(7'h1A), .NUM_REGS(5), .DATA_W(16), .GAP_CYCLES(0), .MAX_RETRY(2)) dut5 (
    .clk(clk), .reset(reset), .init(init5), .tbl_we(tbl_we5), .tbl_addr(tbl_addr5),
    .tbl_wdata(tbl_wdata5), .gen_load(gen_load5), .gen_addr(gen_addr5), .gen_data(gen_data5),
    .gen_ready(gen_ready5), .gen_nack(gen_nack5), .busy(busy5), .done(done5), .error(error5),
    .err_index(err_index5));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_vec = 0;
  int          n_miss = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp5_q[$];
  bit          nack_q[$];
  int          load_cnt = 0;
  int          rdy_at = -1;
  int          last_rdy = 0;
  int          init_cyc = 0;
  int          seq_start = 0;
  bit          prev5 = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Generator model: completes each transaction two cycles after gen_load, NACK taken from nack_q.
  initial forever begin
    @(negedge clk);
    gen_ready = 1'b0;
    gen_nack  = 1'b0;
    if (reset) rdy_at = -1;
    if (cyc == rdy_at) begin
      gen_ready = 1'b1;
      gen_nack  = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
      last_rdy  = cyc;
      rdy_at    = -1;
    end
    if (gen_load) begin
      check_eq("load_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check_eq("gen_data", gen_data, exp_q.pop_front());
      if (load_cnt == seq_start) check_eq("init_to_load", cyc - init_cyc, 1);
      else                       check_eq("ready_to_load", cyc - last_rdy, GAP + 1);
      load_cnt++;
      rdy_at = cyc + 2;
    end
  end

  initial forever begin
    @(negedge clk);
    gen_ready5 = prev5;
    prev5 = gen_load5;
    if (gen_load5) begin
      check_eq("n5_load_expected", exp5_q.size() > 0, 1);
      if (exp5_q.size() > 0) check_eq("n5_gen_data", gen_data5, exp5_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    tbl_we = 1'b1; tbl_addr = a; tbl_wdata = d;
    @(negedge clk);
    tbl_we = 1'b0;
  endtask

  task automatic start();
    init = 1'b1; init_cyc = cyc; seq_start = load_cnt;
    @(negedge clk);
    init = 1'b0;
  endtask

  task automatic finish_seq(input string tag, input bit exp_done, input bit exp_err, input logic [1:0] exp_idx);
    int t = 0;
    while (busy && t < 400) begin @(negedge clk); t++; end
    check_eq({tag, "_in_time"}, t < 400, 1);
    check_eq({tag, "_done"}, done, exp_done);
    check_eq({tag, "_error"}, error, exp_err);
    if (exp_err) check_eq({tag, "_err_index"}, err_index, exp_idx);
    check_eq({tag, "_all_issued"}, exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    check_eq("rst_gen_load", gen_load, 0);
    check_eq("rst_gen_data", gen_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_error", error, 0);
    check_eq("rst_err_index", err_index, 0);
    check_eq("gen_addr", gen_addr, 7'h1A);
    reset = 1'b0;
    @(negedge clk);

    wr(0, 16'h05AA); wr(1, 16'h0112); wr(2, 16'h0255); wr(3, 16'h00DE);
    exp_q = {16'h05AA, 16'h0112, 16'h0255, 16'h00DE};
    start();
    finish_seq("all_ack", 1, 0, 0);
    check_eq("all_ack_busy", busy, 0);

`ifdef I2C_INIT_RETRY_EN
    nack_q = {1'b0, 1'b0, 1'b1, 1'b1};
    exp_q  = {16'h05AA, 16'h0112, 16'h0255, 16'h0255, 16'h0255, 16'h00DE};
    start();
    finish_seq("retry_recover", 1, 0, 0);
    nack_q = {1'b0, 1'b1, 1'b1, 1'b1};
    exp_q  = {16'h05AA, 16'h0112, 16'h0112, 16'h0112};
    start();
    finish_seq("retry_exhaust", 0, 1, 1);
    nack_q = {1'b1, 1'b1, 1'b1};
    exp_q  = {16'h05AA, 16'h05AA, 16'h05AA};
    start();
    finish_seq("nack_idx0", 0, 1, 0);
`else
    nack_q = {1'b0, 1'b0, 1'b1};
    exp_q  = {16'h05AA, 16'h0112, 16'h0255};
    start();
    finish_seq("nack_idx2", 0, 1, 2);
    nack_q = {1'b0, 1'b1};
    exp_q  = {16'h05AA, 16'h0112};
    start();
    finish_seq("nack_idx1", 0, 1, 1);
    nack_q = {1'b1};
    exp_q  = {16'h05AA};
    start();
    finish_seq("nack_idx0", 0, 1, 0);
`endif
    nack_q.delete();

    // Same-cycle write + init, then a write and a second init while busy.
    exp_q = {16'h0A0A, 16'h0112, 16'h0255, 16'h00DE};
    tbl_we = 1'b1; tbl_addr = 2'd0; tbl_wdata = 16'h0A0A;
    start();
    tbl_we = 1'b0;
    @(negedge clk);
    tbl_we = 1'b1; tbl_addr = 2'd1; tbl_wdata = 16'h0177; init = 1'b1;
    @(negedge clk);
    tbl_we = 1'b0; init = 1'b0;
    finish_seq("busy_drop", 1, 0, 0);
    repeat (10) @(negedge clk);
    check_eq("no_restart_busy", busy, 0);

    // Out-of-range index on the five-entry instance.
    for (int k = 0; k < 5; k++) begin
      tbl_we5 = 1'b1; tbl_addr5 = 3'(k); tbl_wdata5 = 16'(16'h0101 * (k + 1));
      exp5_q.push_back(16'(16'h0101 * (k + 1)));
      @(negedge clk);
    end
    tbl_we5 = 1'b1; tbl_addr5 = 3'd5; tbl_wdata5 = 16'hBEEF;
    @(negedge clk);
    tbl_we5 = 1'b0; init5 = 1'b1;
    @(negedge clk);
    init5 = 1'b0;
    t = 0;
    while (busy5 && t < 200) begin @(negedge clk); t++; end
    check_eq("n5_in_time", t < 200, 1);
    check_eq("n5_done", done5, 1);
    check_eq("n5_all_issued", exp5_q.size(), 0);

    // Reset while waiting on entry 2.
    exp_q = {16'h0A0A, 16'h0112, 16'h0255, 16'h00DE};
    start();
    t = 0;
    while (!(gen_load && gen_data == 16'h0255) && t < 200) begin @(negedge clk); t++; end
    check_eq("reach_idx2", t < 200, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_gen_load", gen_load, 0);
    check_eq("abort_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    repeat (4) @(negedge clk);
    check_eq("abort_quiet_busy", busy, 0);
    exp_q = {16'h0000, 16'h0000, 16'h0000, 16'h0000};
    start();
    finish_seq("post_reset", 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
